// File: rtl/loom_reset_pkg.sv
// Shared types and constants for the reset-value re-application block.
package loom_reset_pkg;

   localparam int unsigned DEFAULT_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      CHECK_FETCH,
      CHECK_LOAD,
      DONE
   } reset_apply_state_e;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/loom_reset_piso.sv
// Parallel-in serial-out register: loads one ROM word plus a bit count, shifts LSB first.
module loom_reset_piso #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic [CNT_W-1:0]  count_i,
   output logic              bit_o,
   output logic              last_o
);

   logic [WORD_W-1:0] sreg_reg;
   logic [CNT_W-1:0]  count_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sreg_reg  <= '0;
         count_reg <= '0;
      end else if (load_i) begin
         sreg_reg  <= data_i;
         count_reg <= count_i;
      end else if (shift_i) begin
         sreg_reg  <= {1'b0, sreg_reg[WORD_W-1:1]};
         count_reg <= count_reg - 1'b1;
      end
   end

   assign bit_o  = sreg_reg[0];
   // The bit currently presented is the final one of this word.
   assign last_o = (count_reg == CNT_W'(1));

endmodule

// File: rtl/loom_reset_apply.sv
// Streams stored reset values from a word ROM onto the design scan chain, LSB first.
// Optional checksum verification is enabled by defining LOOM_RESET_APPLY_CHECK_EN.
module loom_reset_apply
   import loom_reset_pkg::*;
#(
   parameter int unsigned  CHAIN_LEN = 72,
   parameter int unsigned  WORD_W    = DEFAULT_WORD_W,
   localparam int unsigned NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W),
   localparam int unsigned ADDR_W    = $clog2(NUM_WORDS + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rom_req_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [WORD_W-1:0] rom_rdata_i,
   output logic              scan_en_o,
   output logic              scan_out_o,
   output logic              error_o
);

   localparam int unsigned      CNT_W     = $clog2(WORD_W + 1);
   localparam int unsigned      LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   reset_apply_state_e state_reg;
   logic [ADDR_W-1:0]  word_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               req_reg;
   logic               scan_en_reg;

   logic               last_word;
   logic               piso_bit;
   logic               piso_last;
   logic [CNT_W-1:0]   piso_count;

   assign last_word  = (word_reg == LAST_ADDR);
   assign piso_count = last_word ? CNT_W'(LAST_BITS) : CNT_W'(WORD_W);

   loom_reset_piso #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_piso (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (state_reg == LOAD),
      .shift_i (state_reg == SHIFT),
      .data_i  (rom_rdata_i),
      .count_i (piso_count),
      .bit_o   (piso_bit),
      .last_o  (piso_last)
   );

   // Outputs are registered alongside the state so they line up with the state they belong to.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= IDLE;
         word_reg    <= '0;
         addr_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         req_reg     <= 1'b0;
         scan_en_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         req_reg  <= 1'b0;
         unique case (state_reg)
            IDLE: begin
               if (start_i) begin
                  state_reg <= FETCH;
                  word_reg  <= '0;
                  addr_reg  <= '0;
                  req_reg   <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            FETCH: state_reg <= LOAD;
            LOAD: begin
               state_reg   <= SHIFT;
               scan_en_reg <= 1'b1;
            end
            SHIFT: begin
               if (piso_last) begin
                  scan_en_reg <= 1'b0;
                  if (!last_word) begin
                     state_reg <= FETCH;
                     word_reg  <= word_reg + 1'b1;
                     addr_reg  <= word_reg + 1'b1;
                     req_reg   <= 1'b1;
                  end else begin
`ifdef LOOM_RESET_APPLY_CHECK_EN
                     state_reg <= CHECK_FETCH;
                     addr_reg  <= ADDR_W'(NUM_WORDS);
                     req_reg   <= 1'b1;
`else
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
`endif
                  end
               end
            end
            CHECK_FETCH: state_reg <= CHECK_LOAD;
            CHECK_LOAD: begin
               state_reg <= DONE;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy_o     = busy_reg;
   assign done_o     = done_reg;
   assign rom_req_o  = req_reg;
   assign rom_addr_o = addr_reg;
   assign scan_en_o  = scan_en_reg;
   assign scan_out_o = scan_en_reg & piso_bit;

`ifdef LOOM_RESET_APPLY_CHECK_EN
   localparam logic [WORD_W-1:0] ALL_ONES  = '1;
   localparam logic [WORD_W-1:0] LAST_MASK = ALL_ONES >> (WORD_W - LAST_BITS);

   logic [WORD_W-1:0] csum_reg;
   logic              error_reg;

   // Bits of the last word beyond the chain never reach a flop, so they are kept out of the sum.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         csum_reg  <= '0;
         error_reg <= 1'b0;
      end else if (state_reg == IDLE && start_i) begin
         csum_reg  <= '0;
         error_reg <= 1'b0;
      end else if (state_reg == LOAD) begin
         csum_reg <= csum_reg ^ (last_word ? (rom_rdata_i & LAST_MASK) : rom_rdata_i);
      end else if (state_reg == CHECK_LOAD) begin
         error_reg <= (rom_rdata_i != csum_reg);
      end
   end

   assign error_o = error_reg;
`else
   assign error_o = 1'b0;
`endif

endmodule
